// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and select sequencer for the shared 4:1 mux datapath.
// Optional build macro MUX_ARB_FIXED_PRIO_EN switches to fixed priority (requester 0 highest).
module mux_rr_arbiter #(
   parameter int WIDTH    = 1,
   parameter int HOLD_MAX = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] x0,
   input  logic [WIDTH-1:0] x1,
   input  logic [WIDTH-1:0] x2,
   input  logic [WIDTH-1:0] x3,
   output logic [3:0]       gnt,
   output logic             c0,
   output logic             c1,
   output logic [WIDTH-1:0] m,
   output logic             m_valid,
   output logic             busy
);

   // state | meaning
   // IDLE  | no requester owns the mux; gnt=0, m_valid falls one edge later
   // GRANT | requester {c1,c0} owns the mux; hold_q counts its grant cycles

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

   state_t           state_q, state_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [1:0]       sel_q, sel_d;
   logic [1:0]       last_q, last_d;
   logic [7:0]       hold_q, hold_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] m_q, mux_d;
   logic             m_valid_q;

   logic [1:0]       win_idle;
   logic [1:0]       win_rel;
   logic             any_req;
   logic             release_grant;

`ifdef MUX_ARB_FIXED_PRIO_EN
   function automatic logic [1:0] fixed_pick(input logic [3:0] r);
      logic [1:0] res;
      res = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (r[k]) res = 2'(k);
      end
      return res;
   endfunction
`else
   // Scan starts one past base and wraps, so base itself is checked last.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
      logic [1:0] res;
      logic [1:0] idx;
      logic       found;
      res   = base;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = base + 2'(k);
         if (!found && r[idx]) begin
            res   = idx;
            found = 1'b1;
         end
      end
      return res;
   endfunction
`endif

   always_comb begin
`ifdef MUX_ARB_FIXED_PRIO_EN
      win_idle = fixed_pick(req);
      win_rel  = fixed_pick(req);
`else
      win_idle = rr_pick(req, last_q);
      win_rel  = rr_pick(req, sel_q);
`endif
   end

   assign any_req       = |req;
   assign release_grant = !req[sel_q] || (hold_q == HOLD_LIM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= 4'b0000;
         sel_q   <= 2'd0;
         last_q  <= 2'd3;
         hold_q  <= 8'd0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      last_d  = last_q;
      hold_d  = hold_q;
      busy_d  = busy_q;
      case (state_q)
         IDLE: begin
            gnt_d  = 4'b0000;
            busy_d = 1'b0;
            if (any_req) begin
               state_d = GRANT;
               gnt_d   = 4'b0001 << win_idle;
               sel_d   = win_idle;
               hold_d  = 8'd1;
               busy_d  = 1'b1;
            end
         end
         GRANT: begin
            if (!release_grant) begin
               hold_d = hold_q + 8'd1;
            end else begin
               last_d = sel_q;
               // Back-to-back handover: the next winner takes over on the same edge.
               if (any_req) begin
                  gnt_d  = 4'b0001 << win_rel;
                  sel_d  = win_rel;
                  hold_d = 8'd1;
               end else begin
                  state_d = IDLE;
                  gnt_d   = 4'b0000;
                  busy_d  = 1'b0;
                  hold_d  = 8'd0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_comb begin
      case (sel_q)
         2'd0:    mux_d = x0;
         2'd1:    mux_d = x1;
         2'd2:    mux_d = x2;
         default: mux_d = x3;
      endcase
   end

   // m_valid lags busy by one edge, matching the one-edge latency of m.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q       <= '0;
         m_valid_q <= 1'b0;
      end else begin
         m_q       <= mux_d;
         m_valid_q <= busy_q;
      end
   end

   assign gnt     = gnt_q;
   assign c0      = sel_q[0];
   assign c1      = sel_q[1];
   assign m       = m_q;
   assign m_valid = m_valid_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (WIDTH=1, HOLD_MAX=4); expected values are hand-derived.
module tb_mux_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [0:0] x0, x1, x2, x3;
   logic [3:0] gnt;
   logic       c0, c1;
   logic [0:0] m;
   logic       m_valid;
   logic       busy;

   int n_pass  = 0;
   int n_total = 0;

   mux_rr_arbiter #(.WIDTH(1), .HOLD_MAX(4)) dut (
      .clk(clk), .rst(rst), .req(req),
      .x0(x0), .x1(x1), .x2(x2), .x3(x3),
      .gnt(gnt), .c0(c0), .c1(c1),
      .m(m), .m_valid(m_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_gnt"}, 32'(gnt), 32'h0);
      check({tag, "_busy"}, 32'(busy), 32'h0);
      check({tag, "_mv"}, 32'(m_valid), 32'h0);
      check({tag, "_sel"}, 32'({c1, c0}), 32'h0);
   endtask

   initial begin
      logic [1:0] exp_sel;
      logic [1:0] prev_sel;
      logic [3:0] xv;

      rst = 1'b1;
      req = 4'b0000;
      x0 = 1'b0; x1 = 1'b0; x2 = 1'b0; x3 = 1'b0;
      tick;
      tick;
      check_idle("rst");
      check("rst_m", 32'(m), 32'h0);
      rst = 1'b0;

      // Test 1: no requests
      for (int i = 0; i < 5; i++) begin
         tick;
         check_idle("t1");
      end

`ifndef MUX_ARB_FIXED_PRIO_EN
      // Test 2: all request, rotation 0,1,2,3,0 with 4-cycle grants
      x0 = 1'b1; x1 = 1'b0; x2 = 1'b1; x3 = 1'b0;
      xv = 4'b0101;
      req = 4'b1111;
      for (int i = 0; i < 20; i++) begin
         tick;
         exp_sel  = 2'((i / 4) % 4);
         prev_sel = (i == 0) ? 2'd0 : 2'(((i - 1) / 4) % 4);
         check("t2_gnt", 32'(gnt), 32'(4'b0001 << exp_sel));
         check("t2_sel", 32'({c1, c0}), 32'(exp_sel));
         check("t2_busy", 32'(busy), 32'h1);
         check("t2_mv", 32'(m_valid), (i >= 1) ? 32'h1 : 32'h0);
         check("t2_m", 32'(m), 32'(xv[prev_sel]));
      end
      req = 4'b0000;
      tick;
      check("t2_rel_gnt", 32'(gnt), 32'h0);
      check("t2_rel_busy", 32'(busy), 32'h0);
      check("t2_rel_mv", 32'(m_valid), 32'h1);
      tick;
      check("t2_idle_mv", 32'(m_valid), 32'h0);
`endif

      // Test 3: single request from 2, data latency
      x0 = 1'b0; x1 = 1'b0; x2 = 1'b1; x3 = 1'b0;
      req = 4'b0100;
      tick;
      check("t3_gnt", 32'(gnt), 32'h4);
      check("t3_sel", 32'({c1, c0}), 32'h2);
      check("t3_mv0", 32'(m_valid), 32'h0);
      check("t3_m0", 32'(m), 32'h0);
      tick;
      check("t3_m1", 32'(m), 32'h1);
      check("t3_mv1", 32'(m_valid), 32'h1);
      req = 4'b0000;
      tick;
      check("t3_drop_gnt", 32'(gnt), 32'h0);
      check("t3_drop_busy", 32'(busy), 32'h0);
      check("t3_drop_mv", 32'(m_valid), 32'h1);
      tick;
      check("t3_idle_mv", 32'(m_valid), 32'h0);
      check("t3_idle_m", 32'(m), 32'h1);
      check("t3_idle_sel", 32'({c1, c0}), 32'h2);

`ifndef MUX_ARB_FIXED_PRIO_EN
      // Test 4: lone requester 3 is re-granted without a gap
      x3 = 1'b1;
      req = 4'b1000;
      for (int i = 0; i < 10; i++) begin
         tick;
         check("t4_gnt", 32'(gnt), 32'h8);
         check("t4_sel", 32'({c1, c0}), 32'h3);
         check("t4_busy", 32'(busy), 32'h1);
      end
      req = 4'b0000;
      tick;
      check("t4_drop_gnt", 32'(gnt), 32'h0);

      // Test 5: reset during the second grant restores requester 0 priority
      x0 = 1'b1; x1 = 1'b1; x2 = 1'b0; x3 = 1'b0;
      req = 4'b0011;
      for (int i = 0; i < 4; i++) begin
         tick;
         check("t5_g0", 32'(gnt), 32'h1);
      end
      tick;
      check("t5_g1", 32'(gnt), 32'h2);
      tick;
      check("t5_g1b", 32'(gnt), 32'h2);
      check("t5_m_pre", 32'(m), 32'h1);
      check("t5_mv_pre", 32'(m_valid), 32'h1);
      rst = 1'b1;
      #1;
      check_idle("t5_async");
      check("t5_async_m", 32'(m), 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      tick;
      check("t5_restart_gnt", 32'(gnt), 32'h1);
      check("t5_restart_sel", 32'({c1, c0}), 32'h0);
`else
      // Test 6: fixed priority keeps requester 0 over requester 3
      req = 4'b0000;
      tick;
      req = 4'b1001;
      for (int i = 0; i < 12; i++) begin
         tick;
         check("t6_gnt", 32'(gnt), 32'h1);
         check("t6_sel", 32'({c1, c0}), 32'h0);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
